alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one registered ALU between NUM_REQ requesters, e.g. the execute stage and an address-gen unit.
//   Round-robin arbitration picks one requester per cycle and drives its operands/ctrl into the ALU.
//   A latency-matched tag pipeline steers each result back to its issuer with a one-hot valid.
//   Illegal ctrl codes are rejected with an error response and never reach the ALU.
// PARAMETERS
//   REG_DATA_WIDTH  32  operand/result width; matches the ALU
//   NUM_REQ         2   number of requesters, 2..8
//   ALU_LATENCY     1   cycles from ALU input to result; the ALU registers on posedge clk
//   ID_WIDTH        clog2(NUM_REQ), min 1; derived, not overridable
// PORTS
//   clk          in   1                    sole clock
//   reset        in   1                    one clock; reset is synchronous and active-high
//   flush        in   1                    kill all in-flight responses
//   req_valid    in   NUM_REQ              per-requester op valid
//   req_ready    out  NUM_REQ              one-hot grant; handshake = valid & ready
//   req_din_0    in   NUM_REQ*W            packed operand 0; requester i at [i*W +: W]
//   req_din_1    in   NUM_REQ*W            packed operand 1
//   req_ctrl     in   NUM_REQ*3            packed ALU op codes
//   alu_din_0    out  W                    to ALU din_0
//   alu_din_1    out  W                    to ALU din_1
//   alu_ctrl     out  3                    to ALU ctrl
//   alu_result   in   W                    from ALU result
//   rsp_valid    out  NUM_REQ              one-hot, one-cycle pulse per response
//   rsp_result   out  W                    result, valid only while any rsp_valid bit is set
//   rsp_err      out  1                    1 = illegal ctrl; rsp_result then 0
//   busy         out  1                    any op in flight
// BEHAVIOUR
// - Reset values: rr_ptr=0; tag pipe cleared; rsp_valid=0, rsp_err=0, busy=0. While reset=1, req_ready=0.
// - Grant (combinational): search req_valid from rr_ptr upward, modulo NUM_REQ; the first set bit wins.
//   req_ready holds at most one bit. A requester never sees ready without its own valid.
// - Pointer: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
// - Issue: the granted operands/ctrl drive alu_* in the same cycle. With no grant, alu_* = 0 and alu_ctrl = 000.
// - Legal ctrl: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND. 001 and 101 are illegal.
//   Illegal op: the handshake still completes and the op consumes the slot.
//   alu_* is forced to 0/000 and the tag carries err=1.
// - Tag pipe: ALU_LATENCY stages of {v, id, err}. Stage 0 loads on a grant.
//   Response appears ALU_LATENCY cycles after the handshake cycle.
//   rsp_valid[id]=v; rsp_result = err ? 0 : alu_result; rsp_err = v & err.
// - Throughput: one issue per cycle with no bubbles. No response backpressure; requesters must sink every rsp.
// - flush: clears every tag v bit in the same edge, so no rsp_valid pulse fires for ops issued before the flush.
//   Grants in the flush cycle are blocked (req_ready=0). rr_ptr is unchanged.
// - Reset mid-operation: same as flush, plus rr_ptr=0. ALU output after reset is ignored because v=0.
// - busy = OR of the tag v bits.
// - NUM_REQ=1: arbitration degenerates to req_ready=req_valid; the id field is constant 0.
// STRUCTURE
// - Shared package alu_pkg:
//   - ALU_CTRL_* localparams (ADD=000, SLT=010, SLTU=011, XOR=100, OR=110, AND=111);
//   - ALU_CTRL_WIDTH=3;
//   - function alu_ctrl_legal(ctrl).
// - Sub-module rr_arbiter(NUM_REQ): req, advance -> one-hot gnt, gnt_id. It owns rr_ptr.
// - Tag pipe, operand mux and response steering stay inline.
// TESTING
// - Single: req0 ADD 5+7 at cycle t -> rsp_valid=01, rsp_result=12 at t+1; busy=1 during t+1.
// - Round-robin: both requesters hold valid for 4 cycles.
//   -> grants alternate 01,10,01,10; responses carry matching ids one cycle later.
// - Illegal: req1 ctrl=101 -> granted; alu_ctrl=000; rsp_valid=10, rsp_err=1, rsp_result=0.
// - SLTU vs SLT: din_0=FFFFFFFF, din_1=1 -> SLT gives 1, SLTU gives 0, on the same requester back-to-back.
// - Flush: issue at t, flush=1 at t -> no rsp at t+1; req_ready=0 at t. Issue at t+1 responds at t+2.
// - Reset mid-stream: reset=1 while an op is in flight -> no rsp pulse, rr_ptr=0.
//   After release, req1 alone is granted on the first cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and helpers for the ALU arbiter
// Purpose: ALU control encodings, legality check and id-width helper.
// Ports: none (package).
package alu_pkg;

  localparam int ALU_CTRL_WIDTH = 3;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD  = 3'b000;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLT  = 3'b010;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLTU = 3'b011;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR  = 3'b100;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR   = 3'b110;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND  = 3'b111;

  // 001 and 101 have no ALU meaning and must never reach the ALU.
  function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_WIDTH-1:0] ctrl);
    case (ctrl)
      ALU_CTRL_ADD, ALU_CTRL_SLT, ALU_CTRL_SLTU,
      ALU_CTRL_XOR, ALU_CTRL_OR, ALU_CTRL_AND: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Requester id width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
// Purpose: pick the first set request at or after rr_ptr (modulo NUM_REQ).
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset, rr_ptr -> 0
//   req_i      per-requester request (already masked by the caller)
//   advance_i  allow the pointer to move past a grant this cycle
//   gnt_o      one-hot grant
//   gnt_id_o   index of the granted requester
module rr_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                advance_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] gnt_id_o
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                found;
  int                  idx;
  int                  nxt;

  // Rotating search; idx wraps manually so NUM_REQ need not be a power of two.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    nxt = int'(gnt_id_o) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_d = (advance_i && found) ? ID_WIDTH'(nxt) : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered ALU between requesters
// Purpose: grant one requester per cycle, drive its op into the ALU, and steer
//   the result back ALU_LATENCY cycles later via a matching tag pipeline.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   flush_i                 drop all in-flight responses, block grants this cycle
//   req_valid_i/req_ready_o per-requester handshake (ready is one-hot)
//   req_din_0_i/_1_i        packed operands, requester i at [i*W +: W]
//   req_ctrl_i              packed 3-bit op codes
//   alu_din_0_o/_1_o/ctrl_o ALU inputs (zero when idle or op illegal)
//   alu_result_i            ALU output
//   rsp_valid_o             one-hot response pulse to the issuer
//   rsp_result_o/rsp_err_o  response data / illegal-op flag
//   busy_o                  any op in flight
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int REG_DATA_WIDTH = 32,
  parameter  int NUM_REQ        = 2,
  parameter  int ALU_LATENCY    = 1,
  localparam int ID_WIDTH       = id_width(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]   req_din_0_i,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]   req_din_1_i,
  input  logic [NUM_REQ*ALU_CTRL_WIDTH-1:0]   req_ctrl_i,
  output logic [REG_DATA_WIDTH-1:0]           alu_din_0_o,
  output logic [REG_DATA_WIDTH-1:0]           alu_din_1_o,
  output logic [ALU_CTRL_WIDTH-1:0]           alu_ctrl_o,
  input  logic [REG_DATA_WIDTH-1:0]           alu_result_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [REG_DATA_WIDTH-1:0]           rsp_result_o,
  output logic                                rsp_err_o,
  output logic                                busy_o
);

  localparam int W    = REG_DATA_WIDTH;
  localparam int LAST = ALU_LATENCY - 1;

  logic                      blocked;
  logic [NUM_REQ-1:0]        req_eff;
  logic [NUM_REQ-1:0]        gnt;
  logic [ID_WIDTH-1:0]       gnt_id;
  logic                      issue;
  logic                      issue_err;
  logic [W-1:0]              sel_din_0, sel_din_1;
  logic [ALU_CTRL_WIDTH-1:0] sel_ctrl;

  logic [ALU_LATENCY-1:0]    tag_v_q;
  logic [ALU_LATENCY-1:0]    tag_err_q;
  logic [ID_WIDTH-1:0]       tag_id_q [ALU_LATENCY];
  logic                      rsp_live;

  // No grant can happen while flushing or in reset, so nothing new enters the pipe.
  assign blocked = flush_i | reset_i;
  assign req_eff = req_valid_i & {NUM_REQ{~blocked}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_eff),
    .advance_i (~blocked),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id)
  );

  assign req_ready_o = gnt;
  assign issue       = |gnt;

  always_comb begin
    sel_din_0 = '0;
    sel_din_1 = '0;
    sel_ctrl  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_din_0 = req_din_0_i[i*W +: W];
        sel_din_1 = req_din_1_i[i*W +: W];
        sel_ctrl  = req_ctrl_i[i*ALU_CTRL_WIDTH +: ALU_CTRL_WIDTH];
      end
    end
  end

  // Illegal ops still consume the slot but present an idle ALU input.
  assign issue_err   = issue & ~alu_ctrl_legal(sel_ctrl);
  assign alu_din_0_o = issue_err ? '0 : sel_din_0;
  assign alu_din_1_o = issue_err ? '0 : sel_din_1;
  assign alu_ctrl_o  = issue_err ? '0 : sel_ctrl;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_v_q   <= '0;
      tag_err_q <= '0;
      for (int k = 0; k < ALU_LATENCY; k++) tag_id_q[k] <= '0;
    end else begin
      tag_v_q[0]   <= issue;
      tag_err_q[0] <= issue_err;
      tag_id_q[0]  <= gnt_id;
      for (int k = 1; k < ALU_LATENCY; k++) begin
        tag_v_q[k]   <= tag_v_q[k-1];
        tag_err_q[k] <= tag_err_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      if (flush_i) tag_v_q <= '0;
    end
  end

  assign busy_o = |tag_v_q;

  // A response sitting at the pipe output in the flush/reset cycle is killed
  // too, so no op issued before the flush ever pulses rsp_valid.
  assign rsp_live = tag_v_q[LAST] & ~blocked;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = rsp_live & (tag_id_q[LAST] == ID_WIDTH'(i));
    end
  end

  assign rsp_err_o    = rsp_live & tag_err_q[LAST];
  assign rsp_result_o = tag_err_q[LAST] ? '0 : alu_result_i;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_din_0;
  logic [63:0] req_din_1;
  logic [5:0]  req_ctrl;
  logic [31:0] alu_din_0;
  logic [31:0] alu_din_1;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result = 32'h0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.REG_DATA_WIDTH(32), .NUM_REQ(2), .ALU_LATENCY(1)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_din_0_i  (req_din_0),
    .req_din_1_i  (req_din_1),
    .req_ctrl_i   (req_ctrl),
    .alu_din_0_o  (alu_din_0),
    .alu_din_1_o  (alu_din_1),
    .alu_ctrl_o   (alu_ctrl),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy)
  );

  // Environment: a one-cycle registered ALU.
  always_ff @(posedge clk) begin
    case (alu_ctrl)
      3'b000:  alu_result <= alu_din_0 + alu_din_1;
      3'b010:  alu_result <= {31'b0, $signed(alu_din_0) < $signed(alu_din_1)};
      3'b011:  alu_result <= {31'b0, alu_din_0 < alu_din_1};
      3'b100:  alu_result <= alu_din_0 ^ alu_din_1;
      3'b110:  alu_result <= alu_din_0 | alu_din_1;
      3'b111:  alu_result <= alu_din_0 & alu_din_1;
      default: alu_result <= 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [1:0]  valid;
    logic        flush;
    logic [2:0]  c0, c1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  e_ready;
    logic [2:0]  e_ctrl;
    logic [31:0] e_din0;
    logic [1:0]  e_rv;
    logic [31:0] e_res;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [1:0] valid, input logic fl,
                              input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [1:0] e_ready, input logic [2:0] e_ctrl,
                              input logic [31:0] e_din0, input logic [1:0] e_rv,
                              input logic [31:0] e_res, input logic e_err, input logic e_busy);
    vec_t v;
    v.valid = valid; v.flush = fl;
    v.c0 = c0; v.a0 = a0; v.b0 = b0;
    v.c1 = c1; v.a1 = a1; v.b1 = b1;
    v.e_ready = e_ready; v.e_ctrl = e_ctrl; v.e_din0 = e_din0;
    v.e_rv = e_rv; v.e_res = e_res; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic [1:0] valid,
                       input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    @(posedge clk);
    #1;
    reset     = rst;
    flush     = fl;
    req_valid = valid;
    req_ctrl  = {c1, c0};
    req_din_0 = {a1, a0};
    req_din_1 = {b1, b0};
    #4;
  endtask

  initial begin
    // Stream of cycles after reset; rsp columns refer to the previous row's issue.
    vecs[0]  = mk(2'b01, 0, 3'b000, 5, 7,                 3'b000, 0, 0,   2'b01, 3'b000, 5,            2'b00, 0,      0, 0);
    vecs[1]  = mk(2'b10, 0, 3'b000, 0, 0,                 3'b111, 6, 3,   2'b10, 3'b111, 6,            2'b01, 12,     0, 1);
    vecs[2]  = mk(2'b11, 0, 3'b100, 32'hF0, 32'h0F,       3'b110, 3, 4,   2'b01, 3'b100, 32'hF0,       2'b10, 2,      0, 1);
    vecs[3]  = mk(2'b11, 0, 3'b100, 32'hF0, 32'h0F,       3'b110, 3, 4,   2'b10, 3'b110, 3,            2'b01, 32'hFF, 0, 1);
    vecs[4]  = mk(2'b11, 0, 3'b100, 32'hF0, 32'h0F,       3'b110, 3, 4,   2'b01, 3'b100, 32'hF0,       2'b10, 7,      0, 1);
    vecs[5]  = mk(2'b11, 0, 3'b100, 32'hF0, 32'h0F,       3'b110, 3, 4,   2'b10, 3'b110, 3,            2'b01, 32'hFF, 0, 1);
    vecs[6]  = mk(2'b10, 0, 3'b000, 0, 0,                 3'b101, 9, 9,   2'b10, 3'b000, 0,            2'b10, 7,      0, 1);
    vecs[7]  = mk(2'b01, 0, 3'b010, 32'hFFFF_FFFF, 1,     3'b000, 0, 0,   2'b01, 3'b010, 32'hFFFF_FFFF, 2'b10, 0,     1, 1);
    vecs[8]  = mk(2'b01, 0, 3'b011, 32'hFFFF_FFFF, 1,     3'b000, 0, 0,   2'b01, 3'b011, 32'hFFFF_FFFF, 2'b01, 1,     0, 1);
    vecs[9]  = mk(2'b00, 0, 3'b000, 0, 0,                 3'b000, 0, 0,   2'b00, 3'b000, 0,            2'b01, 0,      0, 1);
    vecs[10] = mk(2'b00, 0, 3'b000, 0, 0,                 3'b000, 0, 0,   2'b00, 3'b000, 0,            2'b00, 0,      0, 0);
    vecs[11] = mk(2'b01, 1, 3'b000, 1, 2,                 3'b000, 0, 0,   2'b00, 3'b000, 0,            2'b00, 0,      0, 0);
    vecs[12] = mk(2'b01, 0, 3'b000, 1, 2,                 3'b000, 0, 0,   2'b01, 3'b000, 1,            2'b00, 0,      0, 0);
    vecs[13] = mk(2'b00, 0, 3'b000, 0, 0,                 3'b000, 0, 0,   2'b00, 3'b000, 0,            2'b01, 3,      0, 1);
    vecs[14] = mk(2'b10, 0, 3'b000, 0, 0,                 3'b000, 10, 20, 2'b10, 3'b000, 10,           2'b00, 0,      0, 0);
    vecs[15] = mk(2'b01, 1, 3'b000, 1, 2,                 3'b000, 0, 0,   2'b00, 3'b000, 0,            2'b00, 0,      0, 1);
    vecs[16] = mk(2'b00, 0, 3'b000, 0, 0,                 3'b000, 0, 0,   2'b00, 3'b000, 0,            2'b00, 0,      0, 0);

    reset = 1'b1; flush = 1'b0; req_valid = 2'b00;
    req_ctrl = '0; req_din_0 = '0; req_din_1 = '0;

    // Reset state: requests are ignored while reset is held.
    drive(1, 0, 2'b11, 3'b000, 1, 1, 3'b000, 2, 2);
    drive(1, 0, 2'b11, 3'b000, 1, 1, 3'b000, 2, 2);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(0, vecs[i].flush, vecs[i].valid, vecs[i].c0, vecs[i].a0, vecs[i].b0,
            vecs[i].c1, vecs[i].a1, vecs[i].b1);
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].e_ctrl));
      chk($sformatf("v%0d_alu_din0", i), alu_din_0, vecs[i].e_din0);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_rv != 2'b00)
        chk($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].e_res);
    end

    // Reset mid-stream: op in flight is dropped and the pointer returns to 0.
    drive(0, 0, 2'b01, 3'b000, 1, 1, 3'b000, 0, 0);
    chk("mid_issue_ready", 32'(req_ready), 32'h1);
    drive(1, 0, 2'b11, 3'b000, 1, 1, 3'b000, 5, 5);
    chk("mid_reset_ready", 32'(req_ready), 32'h0);
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_reset_rsp_err", 32'(rsp_err), 32'h0);
    drive(0, 0, 2'b11, 3'b000, 1, 1, 3'b000, 5, 5);
    chk("post_reset_ptr0_ready", 32'(req_ready), 32'h1);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_reset_busy", 32'(busy), 32'h0);
    drive(0, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);
    chk("post_reset_rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("post_reset_rsp1_result", rsp_result, 32'h2);
    drive(1, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);
    drive(0, 0, 2'b10, 3'b000, 0, 0, 3'b000, 4, 8);
    chk("req1_alone_ready", 32'(req_ready), 32'h2);
    chk("req1_alone_din0", alu_din_0, 32'h4);
    drive(0, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);
    chk("req1_alone_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("req1_alone_rsp_result", rsp_result, 32'hC);
    drive(0, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);
    chk("idle_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
